// File: rtl/uart_tx_fifo_pkg.sv
// uart_tx_fifo_pkg: shared drain-FSM state encoding and default FIFO depth
package uart_tx_fifo_pkg;
  localparam int UART_TX_FIFO_DEPTH = 16;
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_ACK, S_BUSY} state_t;
endpackage

// File: rtl/uart_tx_fifo_mem.sv
// sync_fifo_mem: DEPTH x 8 storage, one synchronous write port (clk, we, waddr, wdata), combinational read (raddr -> rdata)
module sync_fifo_mem #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [7:0]        wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [7:0]        rdata
);
  logic [7:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: bus-side byte FIFO draining into a UART transmitter; ports clk_bus/rst, push (wr_en/wr_data), flush, ovf_clr, status (full/empty/count/overflow), transmitter handshake (tx_request/tx_data out, tx_idle in)
module uart_tx_fifo
  import uart_tx_fifo_pkg::*;
#(
  parameter int DEPTH  = UART_TX_FIFO_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic            clk_bus,
  input  logic            rst,
  input  logic            wr_en,
  input  logic [7:0]      wr_data,
  input  logic            flush,
  input  logic            ovf_clr,
  output logic            full,
  output logic            empty,
  output logic [ADDR_W:0] count,
  output logic            overflow,
  output logic            tx_request,
  output logic [7:0]      tx_data,
  input  logic            tx_idle
);
  logic [ADDR_W:0] wr_ptr, rd_ptr;
  logic [7:0]      rd_data;
  logic            push, pop, ack_seen;
  state_t          state;
  assign count = wr_ptr - rd_ptr;
  assign empty = wr_ptr == rd_ptr;
  assign full  = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) && (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
  assign push  = wr_en && !full && !flush;
  assign pop   = state == S_IDLE && !empty && tx_idle && !flush;
  sync_fifo_mem #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_mem (
    .clk(clk_bus), .we(push), .waddr(wr_ptr[ADDR_W-1:0]), .wdata(wr_data),
    .raddr(rd_ptr[ADDR_W-1:0]), .rdata(rd_data)
  );
  always_ff @(posedge clk_bus)
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      wr_ptr   <= flush ? '0 : wr_ptr + {{ADDR_W{1'b0}}, push};
      rd_ptr   <= flush ? '0 : rd_ptr + {{ADDR_W{1'b0}}, pop};
      // a dropped push wins over a same-cycle clear
      overflow <= (wr_en && full && !flush) || (overflow && !ovf_clr);
    end
  // ack_seen marks one S_ACK cycle already spent with tx_idle high, so a
  // transmitter that never drops idle still releases the FSM after two cycles
  always_ff @(posedge clk_bus)
    if (rst) begin
      state      <= S_IDLE;
      tx_request <= 1'b0;
      tx_data    <= 8'h00;
      ack_seen   <= 1'b0;
    end else begin
      tx_request <= pop;
      if (pop) tx_data <= rd_data;
      ack_seen   <= state == S_ACK && tx_idle;
      state      <= state == S_IDLE ? (pop ? S_REQ : S_IDLE) :
                    state == S_REQ  ? S_ACK :
                    state == S_ACK  ? (!tx_idle ? S_BUSY : ack_seen ? S_IDLE : S_ACK) :
                    (tx_idle ? S_IDLE : S_BUSY);
    end
endmodule
